// File: rtl/risc_seq_ctrl.sv
// Purpose : multi-cycle sequencer that steps the 16-bit RISC datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Latency : ALU/MVI/JMP/JZ/illegal 3 cycles, STORE 3+N, LOAD 4+N (N = cycles spent waiting for mem_ack).
// Backpr. : data memory stalls the sequencer by withholding mem_ack; run=0 parks it in IDLE after a retire.
//
// Ports
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   run                 request to fetch the next instruction (looked at in IDLE and on a retire)
//   opcode, zero        IR opcode field and ALU zero flag from the datapath
//   mem_ack             data memory completion
//   ir_ld, pc_en, jmp   IR load, PC update, PC-relative jump select
//   reg_wr, sel         register write strobe and write-back mux (00 ALU, 01 mem, 10 imm)
//   mem_rd, mem_wr      data memory requests, held until mem_ack
//   busy, halted        status: executing / stopped on HALT
//   illegal, mem_err    sticky error flags
//   retired             count of completed instructions (wraps)
//
// Optional feature: define RISC_SEQ_MEM_TIMEOUT_EN to abort a memory access after
// MEM_TIMEOUT cycles in MEM without mem_ack. Without it MEM waits forever and mem_err is 0.

module risc_seq_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_ld,
  output logic             pc_en,
  output logic             jmp,
  output logic             reg_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_MVI   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_JZ    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hD;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  state_t             state_q, state_d;
  state_t             after_retire;
  logic [3:0]         opcode_q, opcode_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;

`ifdef RISC_SEQ_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               to_hit;

  // Counts ack-less MEM cycles; anything outside MEM leaves it at zero, so it
  // is already clear on MEM entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_MEM && !mem_ack) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // The MEM_TIMEOUT-th MEM cycle without an ack is the abort cycle.
  assign to_hit = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
`else
  // MEM_TIMEOUT only matters for the timeout build; keep it referenced.
  logic unused_cfg;
  assign unused_cfg = (MEM_TIMEOUT > 0);
`endif

  // Next-state and strobe decode. Outputs are Moore on state/opcode_q/zero_q,
  // except the mem_ack completion terms of the memory phase.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    zero_d       = zero_q;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    ir_ld        = 1'b0;
    pc_en        = 1'b0;
    jmp          = 1'b0;
    reg_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    sel          = SEL_ALU;
    after_retire = run ? S_FETCH : S_IDLE;
`ifdef RISC_SEQ_MEM_TIMEOUT_EN
    mem_err_d    = mem_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_ld   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        opcode_d = opcode;
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        if (!opcode_q[3]) begin
          // 0x0-0x7: ALU op; its zero flag is what a later JZ tests.
          reg_wr  = 1'b1;
          sel     = SEL_ALU;
          pc_en   = 1'b1;
          zero_d  = zero;
          retire  = 1'b1;
          state_d = after_retire;
        end else begin
          case (opcode_q)
            OP_LOAD: begin
              // The request goes out here; an ack in this same cycle skips
              // the MEM wait entirely.
              mem_rd  = 1'b1;
              state_d = mem_ack ? S_WB : S_MEM;
            end
            OP_STORE: begin
              mem_wr = 1'b1;
              if (mem_ack) begin
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = after_retire;
              end else begin
                state_d = S_MEM;
              end
            end
            OP_MVI: begin
              reg_wr  = 1'b1;
              sel     = SEL_IMM;
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = after_retire;
            end
            OP_JMP: begin
              pc_en   = 1'b1;
              jmp     = 1'b1;
              retire  = 1'b1;
              state_d = after_retire;
            end
            OP_JZ: begin
              pc_en   = 1'b1;
              jmp     = zero_q;
              retire  = 1'b1;
              state_d = after_retire;
            end
            OP_HALT: begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default: begin
              // 0xE/0xF: record the fault and step over it like a NOP.
              illegal_d = 1'b1;
              pc_en     = 1'b1;
              retire    = 1'b1;
              state_d   = after_retire;
            end
          endcase
        end
      end

      S_MEM: begin
        // Only LOAD and STORE reach MEM, so opcode_q[0] tells them apart.
        mem_rd = !opcode_q[0];
        mem_wr = opcode_q[0];
        if (mem_ack) begin
          if (opcode_q[0]) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = after_retire;
          end else begin
            state_d = S_WB;
          end
        end
`ifdef RISC_SEQ_MEM_TIMEOUT_EN
        else if (to_hit) begin
          // Abandon the access: drop the request, skip write-back, move on.
          mem_rd    = 1'b0;
          mem_wr    = 1'b0;
          mem_err_d = 1'b1;
          pc_en     = 1'b1;
          retire    = 1'b1;
          state_d   = after_retire;
        end
`endif
      end

      S_WB: begin
        reg_wr  = 1'b1;
        sel     = SEL_MEM;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = after_retire;
      end

      S_HALT: begin
        // Absorbing; only reset leaves.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The flops are about to be cleared, so the datapath must not act on the
    // state being left behind.
    if (reset) begin
      ir_ld  = 1'b0;
      pc_en  = 1'b0;
      jmp    = 1'b0;
      reg_wr = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      sel    = SEL_ALU;
    end

    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= 4'h0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

`ifdef RISC_SEQ_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
